// File: rtl/sysarr_result_collector.sv
// Collects systolic-array output rows into a double-buffered tile store and
// streams completed (or flushed partial) tiles to the writer one row per beat.
module sysarr_result_collector #(
  parameter int N  = 4,
  parameter int DW = 16,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            out_en,
  input  logic [RW-1:0]   row_out,
  input  logic [DW*N-1:0] array_output,
  input  logic            drained,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [RW-1:0]   wr_row,
  output logic [DW*N-1:0] wr_data,
  output logic            wr_last,
  output logic            wr_bank,
  output logic            col_full,
  output logic            tile_done,
  output logic            dup_err,
  output logic            ovf_err,
  input  logic            err_clr
);

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_t;
  typedef enum logic {DRAIN_IDLE, DRAIN_STREAM} drain_t;

  logic [DW*N-1:0] mem [2][N];
  bank_t           bank_st [2];
  logic [N-1:0]    row_mask [2];
  logic            fill_ptr;
  logic            drain_ptr;
  drain_t          dstate;

  logic            cap;
  logic            flush;
  logic            dup_hit;
  logic            ovf_hit;
  logic            xfer_last;
  logic [N-1:0]    cap_onehot;
  logic [N-1:0]    cap_mask;
  logic [N-1:0]    drain_mask;
  logic [RW-1:0]   first_idx;
  logic [RW-1:0]   next_idx;
  logic            has_next;

  assign col_full   = (bank_st[fill_ptr] == BANK_FULL);
  assign cap        = out_en && !col_full;
  assign ovf_hit    = out_en && col_full;
  assign flush      = drained && !out_en && (bank_st[fill_ptr] == BANK_FILLING);
  assign cap_onehot = {{(N-1){1'b0}}, 1'b1} << row_out;
  assign cap_mask   = row_mask[fill_ptr] | cap_onehot;
  assign dup_hit    = cap && |(row_mask[fill_ptr] & cap_onehot);
  assign drain_mask = row_mask[drain_ptr];
  assign xfer_last  = wr_valid && wr_ready && !has_next;
  assign wr_last    = wr_valid && !has_next;
  assign wr_data    = wr_valid ? mem[wr_bank][wr_row] : '0;

  // Descending scan so the final hit is the lowest set bit (overall / above wr_row).
  always_comb begin
    first_idx = '0;
    next_idx  = wr_row;
    has_next  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (drain_mask[i]) begin
        first_idx = RW'(i);
      end
      if (drain_mask[i] && (RW'(i) > wr_row)) begin
        next_idx = RW'(i);
        has_next = 1'b1;
      end
    end
  end

  // Row storage is deliberately left unreset; row_mask says which rows are valid.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[fill_ptr][row_out] <= array_output;
    end
  end

  // Fill side and drain-side release always touch different banks.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b]  <= BANK_EMPTY;
        row_mask[b] <= '0;
      end
      fill_ptr <= 1'b0;
    end else begin
      if (cap) begin
        row_mask[fill_ptr] <= cap_mask;
        if (&cap_mask) begin
          bank_st[fill_ptr] <= BANK_FULL;
          fill_ptr          <= ~fill_ptr;
        end else begin
          bank_st[fill_ptr] <= BANK_FILLING;
        end
      end else if (flush) begin
        bank_st[fill_ptr] <= BANK_FULL;
        fill_ptr          <= ~fill_ptr;
      end
      if (xfer_last) begin
        bank_st[drain_ptr]  <= BANK_EMPTY;
        row_mask[drain_ptr] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dstate    <= DRAIN_IDLE;
      drain_ptr <= 1'b0;
      wr_valid  <= 1'b0;
      wr_row    <= '0;
      wr_bank   <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (dstate)
        DRAIN_IDLE: begin
          if (bank_st[drain_ptr] == BANK_FULL) begin
            dstate   <= DRAIN_STREAM;
            wr_valid <= 1'b1;
            wr_row   <= first_idx;
            wr_bank  <= drain_ptr;
          end
        end
        DRAIN_STREAM: begin
          if (wr_ready) begin
            if (has_next) begin
              wr_row <= next_idx;
            end else begin
              dstate    <= DRAIN_IDLE;
              wr_valid  <= 1'b0;
              wr_row    <= '0;
              wr_bank   <= 1'b0;
              drain_ptr <= ~drain_ptr;
              tile_done <= 1'b1;
            end
          end
        end
        default: begin
          dstate   <= DRAIN_IDLE;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dup_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (dup_hit) begin
        dup_err <= 1'b1;
      end else if (err_clr) begin
        dup_err <= 1'b0;
      end
      if (ovf_hit) begin
        ovf_err <= 1'b1;
      end else if (err_clr) begin
        ovf_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sysarr_result_collector.sv
// Directed bench for sysarr_result_collector: table-driven first tile, then
// hand-written backpressure, double-buffer/overflow, flush, duplicate and reset cases.
module tb_sysarr_result_collector;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 2;

  logic            clk = 1'b0;
  logic            RST;
  logic            out_en;
  logic [RW-1:0]   row_out;
  logic [DW*N-1:0] array_output;
  logic            drained;
  logic            wr_valid;
  logic            wr_ready;
  logic [RW-1:0]   wr_row;
  logic [DW*N-1:0] wr_data;
  logic            wr_last;
  logic            wr_bank;
  logic            col_full;
  logic            tile_done;
  logic            dup_err;
  logic            ovf_err;
  logic            err_clr;

  always #5 clk = ~clk;

  sysarr_result_collector #(.N(N), .DW(DW)) dut (
    .clk(clk), .RST(RST), .out_en(out_en), .row_out(row_out),
    .array_output(array_output), .drained(drained), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data), .wr_last(wr_last),
    .wr_bank(wr_bank), .col_full(col_full), .tile_done(tile_done),
    .dup_err(dup_err), .ovf_err(ovf_err), .err_clr(err_clr)
  );

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    logic            en;
    logic [RW-1:0]   row;
    logic [DW*N-1:0] data;
    logic            drn;
    logic            rdy;
    logic            clr;
    logic            e_valid;
    logic [RW-1:0]   e_row;
    logic [DW*N-1:0] e_data;
    logic            e_last;
    logic            e_bank;
    logic            e_full;
    logic            e_done;
    logic            e_dup;
    logic            e_ovf;
  } vec_t;

  vec_t vecs [10];

  // Expected contents of the tile currently being drained.
  logic [DW*N-1:0] model_row [N];
  logic [N-1:0]    model_mask;

  function automatic logic [DW*N-1:0] pat(input logic [DW-1:0] e);
    return {N{e}};
  endfunction

  // Drive one cycle of inputs, advance past the next rising edge, settle.
  task automatic applyStimulus(input logic en, input logic [RW-1:0] row,
                               input logic [DW*N-1:0] data, input logic drn,
                               input logic rdy, input logic clr);
    out_en = en;
    row_out = row;
    array_output = data;
    drained = drn;
    wr_ready = rdy;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic strict,
                             input logic e_valid, input logic [RW-1:0] e_row,
                             input logic [DW*N-1:0] e_data, input logic e_last,
                             input logic e_bank, input logic e_full,
                             input logic e_done, input logic e_dup, input logic e_ovf);
    logic ok;
    ok = (wr_valid === e_valid) && (col_full === e_full) && (tile_done === e_done) &&
         (dup_err === e_dup) && (ovf_err === e_ovf);
    if (strict || e_valid) begin
      ok = ok && (wr_row === e_row) && (wr_data === e_data) &&
           (wr_last === e_last) && (wr_bank === e_bank);
    end
    check_count++;
    if (!ok) begin
      error_count++;
      $display("[TB] FAIL %s: got valid=%0b row=%0d data=%h last=%0b bank=%0b full=%0b done=%0b dup=%0b ovf=%0b, want valid=%0b row=%0d data=%h last=%0b bank=%0b full=%0b done=%0b dup=%0b ovf=%0b",
               name, wr_valid, wr_row, wr_data, wr_last, wr_bank, col_full, tile_done, dup_err, ovf_err,
               e_valid, e_row, e_data, e_last, e_bank, e_full, e_done, e_dup, e_ovf);
    end
  endtask

  task automatic checkZero(input string name);
    checkOutput(name, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitValid(input string name, input logic rdy);
    int budget;
    budget = 0;
    while (!wr_valid && budget < 20) begin
      applyStimulus(1'b0, '0, '0, 1'b0, rdy, 1'b0);
      budget++;
    end
    check_count++;
    if (!wr_valid) begin
      error_count++;
      $display("[TB] FAIL %s wait: got wr_valid=0 after %0d cycles, want wr_valid=1", name, budget);
    end
  endtask

  task automatic drainTile(input string name, input logic bank, input logic e_full,
                           input logic e_dup, input logic e_ovf, input logic e_full_after);
    logic last;
    waitValid(name, 1'b1);
    for (int r = 0; r < N; r++) begin
      if (model_mask[r]) begin
        last = 1'b1;
        for (int h = r + 1; h < N; h++) begin
          if (model_mask[h]) last = 1'b0;
        end
        checkOutput($sformatf("%s beat row%0d", name, r), 1'b0, 1'b1, RW'(r), model_row[r],
                    last, bank, e_full, 1'b0, e_dup, e_ovf);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      end
    end
    checkOutput($sformatf("%s tile_done", name), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0,
                e_full_after, 1'b1, e_dup, e_ovf);
  endtask

  initial begin
    RST = 1'b1;
    out_en = 1'b0;
    row_out = '0;
    array_output = '0;
    drained = 1'b0;
    wr_ready = 1'b0;
    err_clr = 1'b0;

    // First tile: rows 2,0,3,1 captured, then streamed back in ascending order.
    vecs[0] = '{1'b1, 2'd2, pat(16'h2222), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd0, pat(16'h0000), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd3, pat(16'h3333), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2'd1, pat(16'h1111), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, pat(16'h0000), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, pat(16'h1111), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, pat(16'h2222), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, pat(16'h3333), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkZero("reset state");
    RST = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkZero("after reset release");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].row, vecs[i].data, vecs[i].drn, vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].e_valid, vecs[i].e_row, vecs[i].e_data,
                  vecs[i].e_last, vecs[i].e_bank, vecs[i].e_full, vecs[i].e_done,
                  vecs[i].e_dup, vecs[i].e_ovf);
    end

    // Backpressure: same tile into bank 1, ready pattern 0,0,1 per beat.
    applyStimulus(1'b1, 2'd2, pat(16'h2222), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, pat(16'h0000), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, pat(16'h3333), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, pat(16'h1111), 1'b0, 1'b0, 1'b0);
    waitValid("bp", 1'b0);
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < 3; c++) begin
        checkOutput($sformatf("bp row%0d hold%0d", k, c), 1'b0, 1'b1, RW'(k),
                    pat(DW'(k * 16'h1111)), (k == N - 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, (c == 2), 1'b0);
      end
    end
    checkOutput("bp tile_done", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Double buffer: two tiles stored under wr_ready=0, third tile overflows.
    for (int r = 0; r < N; r++) applyStimulus(1'b1, RW'(r), pat(16'hA000 + 16'(r)), 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) applyStimulus(1'b1, RW'(r), pat(16'hB000 + 16'(r)), 1'b0, 1'b0, 1'b0);
    checkOutput("both banks full", 1'b0, 1'b1, 2'd0, pat(16'hA000), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, pat(16'hC000), 1'b0, 1'b0, 1'b1);
    checkOutput("overflow beats clear", 1'b0, 1'b1, 2'd0, pat(16'hA000), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    model_mask = 4'b1111;
    for (int r = 0; r < N; r++) model_row[r] = pat(16'hA000 + 16'(r));
    drainTile("tile0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < N; r++) model_row[r] = pat(16'hB000 + 16'(r));
    drainTile("tile1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovf cleared", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Partial flush: rows 0 and 2; capture wins over a simultaneous drained.
    applyStimulus(1'b1, 2'd0, pat(16'h5000), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd2, pat(16'h5002), 1'b1, 1'b1, 1'b0);
    checkOutput("flush not yet", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush idle cycle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_mask = 4'b0101;
    model_row[0] = pat(16'h5000);
    model_row[2] = pat(16'h5002);
    drainTile("flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("drained empty%0d", c), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Duplicate row 1: second write wins and dup_err is sticky until cleared.
    applyStimulus(1'b1, 2'd1, pat(16'hAAAA), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd1, pat(16'hBBBB), 1'b0, 1'b1, 1'b0);
    checkOutput("dup set", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, pat(16'hD000), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd2, pat(16'hD002), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, pat(16'hD003), 1'b0, 1'b1, 1'b0);
    model_mask = 4'b1111;
    model_row[0] = pat(16'hD000);
    model_row[1] = pat(16'hBBBB);
    model_row[2] = pat(16'hD002);
    model_row[3] = pat(16'hD003);
    drainTile("dup", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("dup cleared", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream after two accepted beats.
    for (int r = 0; r < N; r++) applyStimulus(1'b1, RW'(r), pat(16'h7000 + 16'(r)), 1'b0, 1'b0, 1'b0);
    waitValid("pre-reset", 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre-reset beat", 1'b0, 1'b1, 2'd2, pat(16'h7002), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    checkZero("async reset");
    @(posedge clk);
    #1;
    RST = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkZero("no stale beat");
    for (int r = 0; r < N; r++) applyStimulus(1'b1, RW'(r), pat(16'h8000 + 16'(r)), 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < N; r++) model_row[r] = pat(16'h8000 + 16'(r));
    drainTile("post-reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
